shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 19 +
 rtl/shift_sequencer_shift_circuit.sv | 20 ++
 rtl/shift_sequencer.sv | 100 ++++++++++
 tb/tb_shift_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared constants and types for the multi-cycle shift sequencer.
//   DATA_W  : operand / result width
//   AMT_W   : shift amount (step count) width
//   state_t : sequencer FSM states
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_shift_circuit.sv
// -----------------------------------------------------------------------------
// shift_circuit
// Combinational one-step logical shifter. It moves the operand by exactly one
// bit position and fills the vacated position with zero.
//   data_in     : operand
//   shift_right : 1 = logical right, 0 = logical left
//   data_out    : operand shifted by one position
// -----------------------------------------------------------------------------
module shift_circuit
    import shift_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic              shift_right,
    output logic [DATA_W-1:0] data_out
);

    assign data_out = shift_right ? {1'b0, data_in[DATA_W-1:1]}
                                  : {data_in[DATA_W-2:0], 1'b0};

endmodule : shift_circuit

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Accepts a shift command over a valid/ready handshake, then applies one
// single-bit logical shift per clock until the requested number of steps has
// been applied. The result is presented over a second valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : command present
//   in_ready   : sequencer idle, command will be accepted
//   in_data    : operand
//   in_dir     : 1 = logical right, 0 = logical left
//   in_amount  : number of single-bit steps (0..7)
//   out_valid  : result present
//   out_ready  : consumer takes the result
//   out_data   : result (the work register in every state)
//   busy       : operation in flight (any state other than IDLE)
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amount,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [AMT_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   step_data;

    // The only datapath element: one single-bit shift of the work register.
    shift_circuit u_shift_circuit (
        .data_in     (work_q),
        .shift_right (dir_q),
        .data_out    (step_data)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    dir_d  = in_dir;
                    cnt_d  = in_amount;
                    // A zero-step command needs no shifting at all.
                    state_d = (in_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Large amounts still run every step; the register simply
                // drains to zero, which keeps the latency equal to the amount.
                work_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic [2:0] in_amount;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected result and expected edges-after-accept latency.
    logic [3:0] exp_q[$];
    int         lat_q[$];

    shift_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amount (in_amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result computed directly from the amount.
    function automatic logic [3:0] model_shift(input logic [3:0] d, input logic dir,
                                               input int amt);
        logic [3:0] r;
        if (amt >= 4) r = 4'b0000;
        else if (dir) r = d >> amt;
        else r = d << amt;
        return r;
    endfunction

    // Amount 0 goes to DONE on the accept edge itself; otherwise one edge per step.
    function automatic int model_lat(input int amt);
        return amt;
    endfunction

    // Present a command, wait for in_ready, let the accept edge happen and
    // record the expectation. Returns #1 after the accept edge, in_valid still high.
    task automatic issue(input logic [3:0] d, input logic dir, input logic [2:0] amt);
        int guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_dir    = dir;
        in_amount = amt;
        while (!in_ready && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%0b required=1 after %0d cycles", in_ready, guard);
        end
        @(posedge clk);
        exp_q.push_back(model_shift(d, dir, int'(amt)));
        lat_q.push_back(model_lat(int'(amt)));
        #1;
    endtask

    // Wait (bounded) for out_valid; out_ready stays low.
    task automatic collect(output logic [3:0] d, output int lat, output bit timed_out);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !out_valid;
        d = out_data;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = 4'h0; in_dir = 1'b0; in_amount = 3'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_out_data: got %b want 0000", out_data); end
    endtask

    task automatic test_left_hold();
        logic [3:0] d, e, held;
        int lat, el;
        bit to;
        issue(4'b1011, 1'b0, 3'd1);
        in_valid = 1'b0;
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL left1_data: got %b want %b timeout=%0b", d, e, to); end
        checks++; if (lat != el) begin errors++; $display("FAIL left1_latency: got %0d want %0d", lat, el); end
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL hold_stable: valid=%b data=%b want valid=1 data=%b", out_valid, out_data, e);
            end
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_right_midchange();
        logic [3:0] d, e;
        int lat, el;
        bit to;
        issue(4'b1101, 1'b1, 3'd2);
        in_valid = 1'b0;
        in_data = 4'b0000; in_dir = 1'b0; in_amount = 3'd7;
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL right2_data: got %b want %b timeout=%0b", d, e, to); end
        checks++; if (lat != el) begin errors++; $display("FAIL right2_latency: got %0d want %0d", lat, el); end
        release_result();
    endtask

    task automatic test_zero_and_large();
        logic [3:0] d, e;
        int lat, el;
        bit to;
        issue(4'b1001, 1'b0, 3'd0);
        in_valid = 1'b0;
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL amt0_data: got %b want %b", d, e); end
        checks++; if (lat != el) begin errors++; $display("FAIL amt0_latency: got %0d want %0d", lat, el); end
        release_result();
        issue(4'b1111, 1'b0, 3'd6);
        in_valid = 1'b0;
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL amt6_data: got %b want %b", d, e); end
        checks++; if (lat != el) begin errors++; $display("FAIL amt6_latency: got %0d want %0d", lat, el); end
        release_result();
    endtask

    task automatic test_sweep();
        logic [3:0] d, e, src;
        logic dir;
        int lat, el;
        bit to;
        for (int a = 0; a < 8; a++) begin
            src = 4'($urandom_range(1, 15));
            dir = 1'($urandom_range(0, 1));
            issue(src, dir, 3'(a));
            in_valid = 1'b0;
            collect(d, lat, to);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++;
            if (to || d !== e || lat != el) begin
                errors++;
                $display("FAIL sweep_amt%0d: src=%b dir=%b got %b lat %0d want %b lat %0d",
                         a, src, dir, d, lat, e, el);
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d, e;
        int lat, el, guard;
        bit to;
        issue(4'b0011, 1'b0, 3'd3);
        // Second command already presented; in_valid stays high throughout.
        in_data = 4'b1100; in_dir = 1'b1; in_amount = 3'd2;
        guard = 0;
        while (!out_valid && guard < 20) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy_ready: ready=%b busy=%b want 0/1", in_ready, busy);
            end
            @(posedge clk); #1;
            guard++;
        end
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL b2b_first_data: got %b want %b", d, e); end
        release_result();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b ready=%b want 0/1", busy, in_ready);
        end
        @(posedge clk);
        exp_q.push_back(model_shift(4'b1100, 1'b1, 2));
        lat_q.push_back(model_lat(2));
        #1 in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        collect(d, lat, to);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (to || d !== e) begin errors++; $display("FAIL b2b_second_data: got %b want %b", d, e); end
        checks++; if (lat != el) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, el); end
        release_result();
    endtask

    task automatic test_rst_abort();
        logic [3:0] e;
        int el;
        bit seen;
        issue(4'b1111, 1'b1, 3'd5);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'b0000) begin
            errors++;
            $display("FAIL rst_abort_state: ready=%b busy=%b valid=%b data=%b want 1/0/0/0000",
                     in_ready, busy, out_valid, out_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_abort_no_valid: out_valid seen=1 want 0"); end
        // Reset wins over an accept in the same cycle.
        in_valid = 1'b1; in_data = 4'b0101; in_dir = 1'b0; in_amount = 3'd3;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_vs_accept: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_left_hold();
        test_right_midchange();
        test_zero_and_large();
        test_sweep();
        test_back_to_back();
        test_rst_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_sequencer
